accept_decider: RTL and testbench

//  Metropolis acceptance stage of the simulated-annealing TSP core. Takes a candidate

---
 rtl/accept_decider.sv | 130 +++++++++++++
 tb/tb_accept_decider.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/accept_decider.sv
// accept_decider: Metropolis acceptance stage of the simulated-annealing TSP core.
// Improving (or equal-cost) moves are accepted at once; worse moves request
// e^-(new-old)*Tinv from the probability computer and compare it with an LFSR draw.
module accept_decider #(
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
  parameter logic [15:0] TIMEOUT   = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] new_cost,
  input  logic [31:0] old_cost,
  input  logic [31:0] tinv,
  output logic [31:0] pc_new,
  output logic [31:0] pc_old,
  output logic [31:0] pc_tinv,
  output logic        pc_inp_valid,
  input  logic [31:0] pc_out,
  input  logic        pc_out_valid,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic        accept,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [31:0] SEED_EFF  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [15:0] WAIT_LAST = TIMEOUT - 16'd1;

  state_t      state, state_n;
  logic [15:0] wait_cnt;
  logic [31:0] lfsr;
  logic        take_req;
  logic        fast_path;
  logic        resp_hit;
  logic        expire;
  logic        resp_accept;

  assign fast_path   = (new_cost <= old_cost);
  assign resp_accept = (pc_out[31:24] != 8'd0) | (lfsr[23:0] < pc_out[23:0]);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_n      = state;
    req_ready    = 1'b0;
    pc_inp_valid = 1'b0;
    dec_valid    = 1'b0;
    take_req     = 1'b0;
    resp_hit     = 1'b0;
    expire       = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so req_ready reads 0 while reset is held.
        req_ready = rst;
        if (req_valid) begin
          take_req = 1'b1;
          state_n  = fast_path ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        pc_inp_valid = 1'b1;
        state_n      = WAIT;
      end
      WAIT: begin
        // A response in the final wait cycle takes priority over the timeout.
        if (pc_out_valid) begin
          resp_hit = 1'b1;
          state_n  = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          expire  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        dec_valid = 1'b1;
        if (dec_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request registers, wait counter and decision flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_new   <= '0;
      pc_old   <= '0;
      pc_tinv  <= '0;
      wait_cnt <= '0;
      accept   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (take_req) begin
        pc_new  <= new_cost;
        pc_old  <= old_cost;
        pc_tinv <= tinv;
        accept  <= fast_path;
        timeout <= 1'b0;
      end
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;
      if (resp_hit) begin
        accept  <= resp_accept;
        timeout <= 1'b0;
      end else if (expire) begin
        accept  <= 1'b0;
        timeout <= 1'b1;
      end
      if (state == DONE && dec_ready) begin
        accept  <= 1'b0;
        timeout <= 1'b0;
      end
    end
  end

  // Galois LFSR, free-running every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= SEED_EFF;
    else      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 32'd0);
  end

endmodule

// File: tb/tb_accept_decider.sv
// Directed self-checking bench for accept_decider: fast path, slow path,
// acceptance statistics, timeout, decision hold and asynchronous reset.
module tb_accept_decider;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, pc_out_valid, dec_ready;
  logic [31:0] new_cost, old_cost, tinv, pc_out;

  logic        req_ready, pc_inp_valid, dec_valid, accept, timeout;
  logic [31:0] pc_new, pc_old, pc_tinv;

  logic        to_req_ready, to_pc_inp_valid, to_dec_valid, to_accept, to_timeout;
  logic [31:0] to_pc_new, to_pc_old, to_pc_tinv;

  int checks   = 0;
  int failures = 0;
  int pc_pulses = 0;

  always #5 clk = ~clk;

  accept_decider u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .new_cost(new_cost), .old_cost(old_cost), .tinv(tinv),
    .pc_new(pc_new), .pc_old(pc_old), .pc_tinv(pc_tinv), .pc_inp_valid(pc_inp_valid),
    .pc_out(pc_out), .pc_out_valid(pc_out_valid),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .accept(accept), .timeout(timeout)
  );

  accept_decider #(.TIMEOUT(16'd16)) u_dut_to (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(to_req_ready),
    .new_cost(new_cost), .old_cost(old_cost), .tinv(tinv),
    .pc_new(to_pc_new), .pc_old(to_pc_old), .pc_tinv(to_pc_tinv), .pc_inp_valid(to_pc_inp_valid),
    .pc_out(pc_out), .pc_out_valid(pc_out_valid),
    .dec_valid(to_dec_valid), .dec_ready(dec_ready), .accept(to_accept), .timeout(to_timeout)
  );

  always @(negedge clk) if (pc_inp_valid) pc_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge while IDLE; returns at the negedge of cycle 1.
  task automatic do_req(input logic [31:0] n, input logic [31:0] o);
    req_valid = 1'b1;
    new_cost  = n;
    old_cost  = o;
    tinv      = 32'h3F80_0000;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic slow_trial(input logic [31:0] p, output logic acc);
    do_req(32'd200, 32'd100);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    pc_out       = p;
    pc_out_valid = 1'b1;
    @(negedge clk);
    pc_out_valid = 1'b0;
    check("trial_dec_valid", {31'd0, dec_valid}, 32'd1);
    acc       = accept;
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
  endtask

  task automatic run_trials(input logic [31:0] p, input int n, output int acc_cnt);
    logic a;
    acc_cnt = 0;
    for (int i = 0; i < n; i++) begin
      slow_trial(p, a);
      if (a) acc_cnt++;
    end
  endtask

  initial begin
    int acc_cnt;
    int n;
    logic a;
    rst = 1'b0; req_valid = 1'b0; pc_out_valid = 1'b0; dec_ready = 1'b0;
    new_cost = '0; old_cost = '0; tinv = '0; pc_out = '0;

    // Reset state.
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_accept", {31'd0, accept}, 32'd0);
    check("rst_pc_inp_valid", {31'd0, pc_inp_valid}, 32'd0);
    check("rst_pc_new", pc_new, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Fast path: improvement.
    do_req(32'd100, 32'd200);
    check("fast_dec_valid", {31'd0, dec_valid}, 32'd1);
    check("fast_accept", {31'd0, accept}, 32'd1);
    check("fast_timeout", {31'd0, timeout}, 32'd0);
    check("fast_req_ready", {31'd0, req_ready}, 32'd0);
    // Release with a request present: it must not be taken in the same cycle.
    dec_ready = 1'b1; req_valid = 1'b1; new_cost = 32'd5; old_cost = 32'd9;
    @(negedge clk);
    dec_ready = 1'b0; req_valid = 1'b0;
    check("release_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("release_req_ready", {31'd0, req_ready}, 32'd1);

    // Equal costs: fast path, accepted.
    do_req(32'd300, 32'd300);
    check("equal_accept", {31'd0, accept}, 32'd1);
    check("equal_dec_valid", {31'd0, dec_valid}, 32'd1);
    dec_ready = 1'b1; @(negedge clk); dec_ready = 1'b0;
    check("fast_no_pc_pulse", pc_pulses, 32'd0);

    // Slow path with integer-part probability, response after 20 cycles.
    do_req(32'd200, 32'd100);
    check("slow_pc_inp_valid", {31'd0, pc_inp_valid}, 32'd1);
    check("slow_pc_new", pc_new, 32'd200);
    check("slow_pc_old", pc_old, 32'd100);
    check("slow_pc_tinv", pc_tinv, 32'h3F80_0000);
    @(negedge clk);
    check("slow_pulse_end", {31'd0, pc_inp_valid}, 32'd0);
    check("slow_wait_req_ready", {31'd0, req_ready}, 32'd0);
    repeat (18) @(negedge clk);
    check("slow_pc_new_held", pc_new, 32'd200);
    pc_out = 32'h0100_0000; pc_out_valid = 1'b1;
    @(negedge clk);
    pc_out_valid = 1'b0;
    check("slow_dec_valid", {31'd0, dec_valid}, 32'd1);
    check("slow_accept", {31'd0, accept}, 32'd1);
    check("slow_timeout", {31'd0, timeout}, 32'd0);
    check("slow_one_pulse", pc_pulses, 32'd1);
    dec_ready = 1'b1; @(negedge clk); dec_ready = 1'b0;

    // Zero probability always rejects.
    for (int i = 0; i < 40; i++) begin
      slow_trial(32'h0000_0000, a);
      check("zero_prob_reject", {31'd0, a}, 32'd0);
    end

    // Near-one probability.
    run_trials(32'h00FF_FFFF, 1000, acc_cnt);
    $display("near-one accepts: %0d/1000", acc_cnt);
    check("near_one_ratio", {31'd0, acc_cnt >= 990}, 32'd1);

    // Half probability.
    run_trials(32'h0080_0000, 1000, acc_cnt);
    $display("half accepts: %0d/1000", acc_cnt);
    check("half_ratio", {31'd0, (acc_cnt >= 450 && acc_cnt <= 550)}, 32'd1);

    // Timeout on the TIMEOUT=16 instance.
    do_reset();
    do_req(32'd200, 32'd100);
    n = 0;
    while (!to_dec_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", n, 32'd17);
    check("to_accept", {31'd0, to_accept}, 32'd0);
    check("to_timeout", {31'd0, to_timeout}, 32'd1);
    dec_ready = 1'b1; @(negedge clk); dec_ready = 1'b0;
    // Stray response in IDLE is ignored.
    pc_out = 32'h0100_0000; pc_out_valid = 1'b1;
    @(negedge clk);
    pc_out_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stray_no_dec", {31'd0, to_dec_valid}, 32'd0);
      @(negedge clk);
    end

    // Response in the same cycle as the timeout wins.
    do_reset();
    do_req(32'd200, 32'd100);
    repeat (16) @(negedge clk);
    pc_out = 32'h0100_0000; pc_out_valid = 1'b1;
    @(negedge clk);
    pc_out_valid = 1'b0;
    check("race_dec_valid", {31'd0, to_dec_valid}, 32'd1);
    check("race_accept", {31'd0, to_accept}, 32'd1);
    check("race_timeout", {31'd0, to_timeout}, 32'd0);

    // Decision held while dec_ready is low.
    do_reset();
    do_req(32'd10, 32'd20);
    for (int i = 0; i < 10; i++) begin
      check("hold_dec_valid", {31'd0, dec_valid}, 32'd1);
      check("hold_accept", {31'd0, accept}, 32'd1);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    dec_ready = 1'b1; @(negedge clk); dec_ready = 1'b0;

    // Asynchronous reset mid-WAIT.
    do_req(32'd200, 32'd100);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_pc_new", pc_new, 32'd0);
    check("arst_pc_old", pc_old, 32'd0);
    check("arst_pc_tinv", pc_tinv, 32'd0);
    check("arst_pc_inp_valid", {31'd0, pc_inp_valid}, 32'd0);
    check("arst_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("arst_accept", {31'd0, accept}, 32'd0);
    check("arst_timeout", {31'd0, timeout}, 32'd0);
    check("arst_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    pc_out = 32'h0100_0000; pc_out_valid = 1'b1;
    @(negedge clk);
    pc_out_valid = 1'b0;
    check("post_rst_no_dec", {31'd0, dec_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
